// File: rtl/syscall_read_string.sv
// syscall_read_string: services MIPS read_string (syscall 8). Pulls bytes
// from a console stream into data memory at $a0, bounded by $a1 bytes
// including the NUL terminator, while holding the pipeline through stall.
// Outputs are decoded from state and the current handshake, so a byte is
// written in the same cycle it is accepted.
module syscall_read_string #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned LEN_W   = 32,
    parameter logic [7:0]  NEWLINE = 8'h0A
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] buf_addr,
    input  logic [LEN_W-1:0]  max_len,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              stall,
    output logic              done,
    output logic [LEN_W-1:0]  count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RECV = 2'd1;
    localparam logic [1:0] S_TERM = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        state;
    logic [1:0]        state_nx;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] base_nx;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  len_nx;
    logic [LEN_W-1:0]  cnt;
    logic [LEN_W-1:0]  cnt_nx;
    logic [ADDR_W-1:0] wr_ptr;

    assign count  = cnt;
    // Next write address; wraps modulo 2^ADDR_W by design.
    assign wr_ptr = base + ADDR_W'(cnt);

    // State, buffer base, length and stored-character count registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            base  <= '0;
            len   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            base  <= base_nx;
            len   <= len_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_nx  = state;
        base_nx   = base;
        len_nx    = len;
        cnt_nx    = cnt;
        in_ready  = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = 8'h00;
        stall     = 1'b0;
        done      = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    stall   = 1'b1;
                    base_nx = buf_addr;
                    len_nx  = max_len;
                    cnt_nx  = '0;
                    if (max_len == '0) begin
                        state_nx = S_DONE;
                    end else if (max_len == LEN_W'(1)) begin
                        state_nx = S_TERM;
                    end else begin
                        state_nx = S_RECV;
                    end
                end
            end
            S_RECV: begin
                stall    = 1'b1;
                in_ready = 1'b1;
                if (in_valid) begin
                    if (in_data == 8'h00) begin
                        state_nx = S_TERM;
                    end else begin
                        mem_we    = 1'b1;
                        mem_addr  = wr_ptr;
                        mem_wdata = in_data;
                        cnt_nx    = cnt + LEN_W'(1);
                        // Leave room for the terminator in the last slot.
                        if ((in_data == NEWLINE) ||
                            (cnt + LEN_W'(1) == len - LEN_W'(1))) begin
                            state_nx = S_TERM;
                        end
                    end
                end
            end
            S_TERM: begin
                stall    = 1'b1;
                mem_we   = 1'b1;
                mem_addr = wr_ptr;
                state_nx = S_DONE;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        // Reset silences the block in the cycle it is asserted.
        if (reset) begin
            in_ready  = 1'b0;
            mem_we    = 1'b0;
            mem_addr  = '0;
            mem_wdata = 8'h00;
            stall     = 1'b0;
            done      = 1'b0;
        end
    end

endmodule

// File: tb/tb_syscall_read_string.sv
// Testbench for syscall_read_string: table vectors, hand sequences for reset
// and ignored starts, and randomized transactions against a reference model.
module tb_syscall_read_string;

    localparam logic [7:0] NL = 8'h0A;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] buf_addr;
    logic [31:0] max_len;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        stall;
    logic        done;
    logic [31:0] count;

    always #5 clk = ~clk;

    syscall_read_string dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .buf_addr (buf_addr),
        .max_len  (max_len),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .stall    (stall),
        .done     (done),
        .count    (count)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [7:0]  d;
    } wr_t;

    typedef struct {
        logic [31:0] base;
        logic [31:0] len;
        string       s;       // '~' stands for a 0x00 byte
        string       vpat;    // in_valid per RECV cycle; empty means always 1
        int          restart; // cycle to pulse a spurious start, 0 = none
        int          exp_count;
        int          exp_stall;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    byte unsigned stream[$];
    bit           vbits[$];
    wr_t          got_wr[$];
    wr_t          exp_wr[$];
    int got_stall, got_done, got_consumed, junk, we_no_hs, stall_gap;
    logic [31:0] got_count;
    int exp_count, exp_stall, exp_consumed;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic load(input string s, input string vp);
        stream.delete();
        vbits.delete();
        for (int i = 0; i < s.len(); i++)
            stream.push_back((s[i] == 8'h7E) ? 8'h00 : s[i]);
        for (int i = 0; i < vp.len(); i++)
            vbits.push_back(vp[i] == "1");
    endtask

    function automatic byte unsigned sbyte(input int i);
        return (i < stream.size()) ? stream[i] : NL;
    endfunction

    function automatic bit vbit(input int k);
        return (k < vbits.size()) ? vbits[k] : 1'b1;
    endfunction

    // Reference: what the syscall should store, and for how long it stalls.
    task automatic model(input logic [31:0] base, input logic [31:0] len);
        int stored = 0;
        int recv = 0;
        int seen = 0;
        byte unsigned b;
        exp_wr.delete();
        exp_consumed = 0;
        if (len == 0) begin
            exp_count = 0;
            exp_stall = 1;
            return;
        end
        if (len > 1) begin
            forever begin
                b = sbyte(exp_consumed);
                exp_consumed++;
                if (b == 8'h00) break;
                exp_wr.push_back('{a: base + 32'(stored), d: b});
                stored++;
                if (b == NL || stored == int'(len) - 1) break;
            end
        end
        exp_wr.push_back('{a: base + 32'(stored), d: 8'h00});
        while (seen < exp_consumed) begin
            if (vbit(recv)) seen++;
            recv++;
        end
        exp_count = stored;
        exp_stall = recv + 2;
    endtask

    // Drives one syscall and records everything the DUT does until done.
    task automatic run_txn(input logic [31:0] base, input logic [31:0] len, input int restart_cyc);
        int idx = 0;
        int after_done = -1;
        bit stall_fell = 0;
        got_wr.delete();
        got_stall = 0; got_done = 0; junk = 0; we_no_hs = 0; stall_gap = 0;
        got_count = '1;
        @(posedge clk); #1;
        start = 1'b1; buf_addr = base; max_len = len;
        in_valid = 1'b0; in_data = sbyte(0);
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            if (mem_we) got_wr.push_back('{a: mem_addr, d: mem_wdata});
            else if (mem_addr != 0 || mem_wdata != 0) junk++;
            if (mem_we && in_ready && !in_valid) we_no_hs++;
            if (stall) begin
                got_stall++;
                if (stall_fell) stall_gap++;
            end else if (got_stall > 0) begin
                stall_fell = 1;
            end
            if (in_valid && in_ready) idx++;
            if (done) begin
                got_done++;
                got_count = count;
                if (after_done < 0) after_done = cyc;
            end
            if (after_done >= 0 && cyc >= after_done + 3) break;
            @(posedge clk); #1;
            start    = (cyc + 1 == restart_cyc);
            buf_addr = start ? 32'hDEAD0000 : base;
            max_len  = start ? 32'd2 : len;
            in_valid = vbit(cyc);
            in_data  = sbyte(idx);
        end
        start = 1'b0;
        in_valid = 1'b0;
        got_consumed = idx;
    endtask

    task automatic compare_txn(input string tag);
        check({tag, ".count"}, got_count, exp_count);
        check({tag, ".stall_cycles"}, got_stall, exp_stall);
        check({tag, ".done_pulses"}, got_done, 1);
        check({tag, ".consumed"}, got_consumed, exp_consumed);
        check({tag, ".num_writes"}, got_wr.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++)
            check($sformatf("%s.write%0d", tag, i), got_wr[i], exp_wr[i]);
        check({tag, ".idle_bus_zero"}, junk, 0);
        check({tag, ".write_without_handshake"}, we_no_hs, 0);
        check({tag, ".stall_contiguous"}, stall_gap, 0);
    endtask

    vec_t vecs[$];

    initial begin
        int bad;
        vecs.push_back('{32'h1000, 16, "Hi\n", "", 0, 3, 5});
        vecs.push_back('{32'h2000, 4, "abcdef", "", 0, 3, 5});
        vecs.push_back('{32'h3000, 0, "xyz", "", 0, 0, 1});
        vecs.push_back('{32'h4000, 1, "xyz", "", 0, 0, 2});
        vecs.push_back('{32'h5000, 16, "ok\n", "100101", 0, 3, 8});
        vecs.push_back('{32'hFFFFFFFE, 8, "wrap\n", "", 0, 5, 7});
        vecs.push_back('{32'h7000, 8, "ab~cd", "", 0, 2, 5});
        vecs.push_back('{32'h8000, 16, "hello\n", "", 3, 6, 8});
        vecs.push_back('{32'h9000, 16, "Hi\n", "", 5, 3, 5});

        reset = 1'b1; start = 1'b0; buf_addr = '0; max_len = '0;
        in_valid = 1'b0; in_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset.stall", stall, 0);
        check("reset.in_ready", in_ready, 0);
        check("reset.mem_we", mem_we, 0);
        check("reset.done", done, 0);
        check("reset.count", count, 0);
        check("reset.mem_addr", mem_addr, 0);
        @(posedge clk); #1 reset = 1'b0;

        foreach (vecs[v]) begin
            load(vecs[v].s, vecs[v].vpat);
            model(vecs[v].base, vecs[v].len);
            run_txn(vecs[v].base, vecs[v].len, vecs[v].restart);
            compare_txn($sformatf("vec%0d", v));
            check($sformatf("vec%0d.table_count", v), got_count, vecs[v].exp_count);
            check($sformatf("vec%0d.table_stall", v), got_stall, vecs[v].exp_stall);
        end

        // Reset after two stored bytes: silent, unterminated, then a fresh run.
        load("abcdef", "");
        @(posedge clk); #1 start = 1'b1; buf_addr = 32'h6000; max_len = 16;
        @(posedge clk); #1 start = 1'b0; in_valid = 1'b1; in_data = "a";
        @(posedge clk); #1 in_data = "b";
        @(posedge clk); #1 reset = 1'b1; in_data = "c";
        @(negedge clk);
        check("midreset.stall", stall, 0);
        check("midreset.in_ready", in_ready, 0);
        check("midreset.mem_we", mem_we, 0);
        @(posedge clk); #1 reset = 1'b0;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (mem_we || stall || in_ready || done) bad++;
        end
        check("midreset.quiet_after", bad, 0);
        check("midreset.count", count, 0);
        in_valid = 1'b0;
        load("Hi\n", "");
        model(32'h6000, 8);
        run_txn(32'h6000, 8, 0);
        compare_txn("after_reset");

        // Randomized transactions.
        for (int r = 0; r < 25; r++) begin
            logic [31:0] base;
            logic [31:0] len;
            int rs;
            base = $urandom;
            len  = $urandom_range(0, 12);
            stream.delete();
            vbits.delete();
            for (int i = 0; i < 15; i++) begin
                int p;
                p = $urandom_range(0, 19);
                stream.push_back(p == 0 ? 8'h00 : p == 1 ? NL : 8'($urandom_range(33, 126)));
            end
            stream.push_back(NL);
            for (int i = 0; i < 40; i++) vbits.push_back($urandom_range(0, 9) < 7);
            model(base, len);
            rs = ($urandom_range(0, 1) == 1) ? $urandom_range(1, exp_stall) : 0;
            run_txn(base, len, rs);
            compare_txn($sformatf("rand%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
